// File: rtl/host_dma_pkg.sv
// Shared types and defaults for the host DMA arbiter.
// Holds the arbiter FSM encoding and bus width defaults.
package host_dma_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 64;
  localparam int unsigned DEF_DATA_WIDTH = 512;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_POP,
    RD_DRAIN,
    WR_ISSUE,
    WR_PUSH,
    WR_DRAIN,
    DONE
  } state_t;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick among level requests.
// Search starts one past the previous winner.
module rr_arbiter
  import host_dma_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] w_k;

  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_k    = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      w_k = IW'((32'(i_last) + 32'(i)) % NUM_REQ);
      if (!o_any && i_req[w_k]) begin
        o_any       = 1'b1;
        o_idx       = w_k;
        o_pick[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/host_dma_arbiter.sv
// Shares one read/write DMA pair between instruction and data sides.
// One cache line per transaction; owner holds grant until done.
module host_dma_arbiter
  import host_dma_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          dma_rd_go,
  output logic                          dma_wr_go,
  output logic [ADDR_WIDTH-1:0]         dma_rd_addr,
  output logic [ADDR_WIDTH-1:0]         dma_wr_addr,
  output logic                          dma_rd_en,
  input  logic [DATA_WIDTH-1:0]         dma_rd_data,
  input  logic                          dma_empty,
  input  logic                          dma_rd_done,
  output logic                          dma_wr_en,
  output logic [DATA_WIDTH-1:0]         dma_wr_data,
  input  logic                          dma_full,
  input  logic                          dma_wr_done
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           r_last;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [NUM_REQ-1:0]      r_grant;

  logic [NUM_REQ-1:0]      w_pick;
  logic [IW-1:0]           w_idx;
  logic                    w_any;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_addr_a[g]  =
      req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_a[g] =
      req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .i_req  (req),
    .i_last (r_last),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_we = req_we[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_grant <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx   <= w_idx;
            r_we    <= w_we;
            r_addr  <= w_addr_a[w_idx];
            r_wdata <= w_wdata_a[w_idx];
            r_grant <= w_pick;
            r_state <= w_we ? WR_ISSUE
                            : RD_ISSUE;
          end
        end
        RD_ISSUE: r_state <= RD_POP;
        RD_POP: begin
          if (!dma_empty) begin
            r_rdata <= dma_rd_data;
            r_state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (dma_rd_done) r_state <= DONE;
        end
        WR_ISSUE: r_state <= WR_PUSH;
        WR_PUSH: begin
          if (!dma_full) r_state <= WR_DRAIN;
        end
        WR_DRAIN: begin
          if (dma_wr_done) r_state <= DONE;
        end
        DONE: begin
          r_last  <= r_idx;
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes decode the registered state so reset kills them at once.
  assign busy        = (r_state != IDLE);
  assign grant       = r_grant;
  assign done        = (r_state == DONE) ? r_grant : '0;
  assign rdata       = r_rdata;
  assign dma_rd_go   = (r_state == RD_ISSUE);
  assign dma_wr_go   = (r_state == WR_ISSUE);
  assign dma_rd_en   = (r_state == RD_POP) & ~dma_empty;
  assign dma_wr_en   = (r_state == WR_PUSH) & ~dma_full;
  assign dma_rd_addr = r_addr;
  assign dma_wr_addr = r_addr;
  assign dma_wr_data = r_wdata;

endmodule

// File: tb/tb_host_dma_arbiter.sv
// Bench for host_dma_arbiter: directed scenarios plus random traffic
// checked each cycle against a transaction-level model.
module tb_host_dma_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            dma_rd_go;
  logic            dma_wr_go;
  logic [AW-1:0]   dma_rd_addr;
  logic [AW-1:0]   dma_wr_addr;
  logic            dma_rd_en;
  logic [DW-1:0]   dma_rd_data = '0;
  logic            dma_empty = 1'b1;
  logic            dma_rd_done = 1'b0;
  logic            dma_wr_en;
  logic [DW-1:0]   dma_wr_data;
  logic            dma_full = 1'b1;
  logic            dma_wr_done = 1'b0;

  host_dma_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .grant       (grant),
    .done        (done),
    .rdata       (rdata),
    .busy        (busy),
    .dma_rd_go   (dma_rd_go),
    .dma_wr_go   (dma_wr_go),
    .dma_rd_addr (dma_rd_addr),
    .dma_wr_addr (dma_wr_addr),
    .dma_rd_en   (dma_rd_en),
    .dma_rd_data (dma_rd_data),
    .dma_empty   (dma_empty),
    .dma_rd_done (dma_rd_done),
    .dma_wr_en   (dma_wr_en),
    .dma_wr_data (dma_wr_data),
    .dma_full    (dma_full),
    .dma_wr_done (dma_wr_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed events
  int          rd_go_cnt = 0, wr_go_cnt = 0;
  int          rd_en_cnt = 0, wr_en_cnt = 0;
  int          rd_go_cyc = 0, wr_go_cyc = 0, wr_en_cyc = 0;
  int          done_cnt [N];
  int          done_cyc [N];
  logic [AW-1:0] rd_go_addr = '0, wr_go_addr = '0;
  logic [DW-1:0] wr_en_data = '0;
  int          gorder [$];
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] saw_done = '0;

  // Transaction-level model of the one outstanding line transfer
  bit          m_act, m_iss, m_mov, m_drn, m_we;
  int          m_own, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  initial begin
    for (int i = 0; i < N; i++) begin
      done_cnt[i] = 0;
      done_cyc[i] = 0;
    end
    m_act = 0; m_iss = 0; m_mov = 0; m_drn = 0; m_we = 0;
    m_own = 0; m_last = N - 1;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  end

  always @(negedge clk) begin : mon
    logic [N-1:0] e_grant, e_done;
    logic e_rgo, e_wgo, e_ren, e_wen;
    logic [2*N+4+2*AW:0] act_v, exp_v;
    bit found;
    int c;
    if (!rst_n) begin
      m_act = 0; m_iss = 0; m_mov = 0; m_drn = 0; m_we = 0;
      m_own = 0; m_last = N - 1;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end
    e_grant = m_act ? N'(1 << m_own) : '0;
    e_done  = (m_act && m_drn) ? e_grant : '0;
    e_rgo   = m_act && !m_we && !m_iss;
    e_wgo   = m_act && m_we && !m_iss;
    e_ren   = m_act && !m_we && m_iss && !m_mov && !dma_empty;
    e_wen   = m_act && m_we && m_iss && !m_mov && !dma_full;
    act_v = {grant, done, busy, dma_rd_go, dma_wr_go,
             dma_rd_en, dma_wr_en, dma_rd_addr, dma_wr_addr};
    exp_v = {e_grant, e_done, 1'(m_act), e_rgo, e_wgo,
             e_ren, e_wen, m_addr, m_addr};
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL ctrl cyc=%0d got=%h exp=%h",
               cyc, act_v, exp_v);
    end
    n_chk++;
    if (rdata !== m_rdata) begin
      n_fail++;
      $display("FAIL rdata cyc=%0d got=%h exp=%h",
               cyc, rdata, m_rdata);
    end
    n_chk++;
    if (dma_wr_data !== m_wdata) begin
      n_fail++;
      $display("FAIL wr_data cyc=%0d got=%h exp=%h",
               cyc, dma_wr_data, m_wdata);
    end
    n_chk++;
    if ($countones({dma_rd_go, dma_wr_go, dma_rd_en,
                    dma_wr_en}) > 1 || !$onehot0(grant)) begin
      n_fail++;
      $display("FAIL excl cyc=%0d got=%b grant=%b exp=onehot0",
               cyc, {dma_rd_go, dma_wr_go, dma_rd_en,
               dma_wr_en}, grant);
    end

    if (dma_rd_go) begin
      rd_go_cnt++; rd_go_cyc = cyc; rd_go_addr = dma_rd_addr;
    end
    if (dma_wr_go) begin
      wr_go_cnt++; wr_go_cyc = cyc; wr_go_addr = dma_wr_addr;
    end
    if (dma_rd_en) rd_en_cnt++;
    if (dma_wr_en) begin
      wr_en_cnt++; wr_en_cyc = cyc; wr_en_data = dma_wr_data;
    end
    for (int i = 0; i < N; i++)
      if (done[i]) begin
        done_cnt[i]++; done_cyc[i] = cyc;
      end
    if (grant != '0 && prev_grant == '0)
      gorder.push_back(grant[1] ? 1 : 0);
    prev_grant = grant;
    saw_done = done;

    if (rst_n) begin
      if (!m_act) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && req[c]) begin
            found = 1;
            m_own = c;
          end
        end
        if (found) begin
          m_act = 1; m_iss = 0; m_mov = 0; m_drn = 0;
          m_we = req_we[m_own];
          m_addr = req_addr[m_own*AW +: AW];
          m_wdata = req_wdata[m_own*DW +: DW];
        end
      end else if (!m_iss) begin
        m_iss = 1;
      end else if (!m_mov) begin
        if (m_we ? !dma_full : !dma_empty) begin
          m_mov = 1;
          if (!m_we) m_rdata = dma_rd_data;
        end
      end else if (!m_drn) begin
        if (m_we ? dma_wr_done : dma_rd_done) m_drn = 1;
      end else begin
        m_act = 0;
        m_last = m_own;
      end
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int r);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (saw_done[r]) begin
        req[r] = 1'b0;
        break;
      end
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int start, s_go, s_en, s_d0, s_d1;
    logic [DW-1:0] pat_r, pat_w;
    pat_r = {64{8'hA5}};
    pat_w = {16{32'h1234_5678}};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({grant, done, busy, dma_rd_go,
          dma_wr_go, dma_rd_en, dma_wr_en}), 64'h0);
    check("rst_rdata", 64'(|rdata), 64'h0);
    rst_n = 1'b1;

    // Minimum latency read, requester 0
    dma_empty = 1'b0;
    dma_rd_done = 1'b1;
    req_we[0] = 1'b0;
    req_addr[0*AW +: AW] = 64'h40;
    tick();
    req[0] = 1'b1;
    start = cyc;
    wait_done(0);
    check("lat_rd_go", 64'(rd_go_cyc - start), 64'd1);
    check("lat_done", 64'(done_cyc[0] - start), 64'd4);
    check("lat_addr", rd_go_addr, 64'h40);

    // Read from data side with slow channel
    dma_empty = 1'b1;
    dma_rd_done = 1'b0;
    dma_rd_data = pat_r;
    req_we[1] = 1'b0;
    req_addr[1*AW +: AW] = 64'h1000;
    s_go = rd_go_cnt; s_en = rd_en_cnt;
    s_d0 = done_cnt[0]; s_d1 = done_cnt[1];
    req[1] = 1'b1;
    for (int k = 0; k < 20 && rd_go_cnt == s_go; k++) tick();
    tick();
    tick();
    dma_empty = 1'b0;
    tick();
    dma_empty = 1'b1;
    dma_rd_done = 1'b1;
    wait_done(1);
    dma_rd_done = 1'b0;
    check("rd_go_cnt", 64'(rd_go_cnt - s_go), 64'd1);
    check("rd_go_addr", rd_go_addr, 64'h1000);
    check("rd_en_cnt", 64'(rd_en_cnt - s_en), 64'd1);
    check("rdata_lo", rdata[63:0], 64'hA5A5A5A5A5A5A5A5);
    check("rdata_hi", rdata[DW-1 -: 64], 64'hA5A5A5A5A5A5A5A5);
    check("rd_done1", 64'(done_cnt[1] - s_d1), 64'd1);
    check("rd_done0", 64'(done_cnt[0] - s_d0), 64'd0);

    // Write with back-pressure; requester drops req in drain
    dma_full = 1'b1;
    dma_wr_done = 1'b0;
    req_we[0] = 1'b1;
    req_addr[0*AW +: AW] = 64'h2040;
    req_wdata[0*DW +: DW] = pat_w;
    s_go = wr_go_cnt; s_en = wr_en_cnt;
    s_d0 = done_cnt[0]; s_d1 = done_cnt[1];
    req[0] = 1'b1;
    for (int k = 0; k < 20 && wr_go_cnt == s_go; k++) tick();
    repeat (4) tick();
    dma_full = 1'b0;
    for (int k = 0; k < 20 && wr_en_cnt == s_en; k++) tick();
    dma_full = 1'b1;
    req[0] = 1'b0;
    tick();
    tick();
    dma_wr_done = 1'b1;
    for (int k = 0; k < 20 && done_cnt[0] == s_d0; k++) tick();
    dma_wr_done = 1'b0;
    check("wr_go_cnt", 64'(wr_go_cnt - s_go), 64'd1);
    check("wr_go_addr", wr_go_addr, 64'h2040);
    check("wr_en_cnt", 64'(wr_en_cnt - s_en), 64'd1);
    check("wr_en_wait", 64'(wr_en_cyc - wr_go_cyc), 64'd5);
    check("wr_data_lo", wr_en_data[63:0], 64'h1234567812345678);
    check("wr_data_hi", wr_en_data[DW-1 -: 64],
          64'h1234567812345678);
    check("wr_done0", 64'(done_cnt[0] - s_d0), 64'd1);
    check("wr_done1", 64'(done_cnt[1] - s_d1), 64'd0);

    // Reset during RD_POP, then contention from reset
    tick();
    dma_empty = 1'b1;
    req_we[1] = 1'b0;
    req_addr[1*AW +: AW] = 64'h3000;
    dma_rd_data = rnd_line();
    s_go = rd_go_cnt;
    req[1] = 1'b1;
    for (int k = 0; k < 20 && rd_go_cnt == s_go; k++) tick();
    tick();
    dma_empty = 1'b0;
    #1;
    check("pre_rst_rd_en", 64'(dma_rd_en), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({grant, done, busy, dma_rd_go,
          dma_wr_go, dma_rd_en, dma_wr_en}), 64'h0);
    check("mid_rst_addr", dma_rd_addr | dma_wr_addr, 64'h0);
    check("mid_rst_rdata", 64'(|rdata), 64'h0);
    check("mid_rst_wdata", 64'(|dma_wr_data), 64'h0);
    s_d1 = done_cnt[1];
    req = '0;
    tick();
    tick();
    check("no_abort_done", 64'(done_cnt[1] - s_d1), 64'd0);
    rst_n = 1'b1;
    req_we = '0;
    dma_rd_done = 1'b1;
    gorder.delete();
    req = 2'b11;
    repeat (24) tick();
    req = '0;
    for (int i = 0; i < 4; i++)
      check($sformatf("grant_order%0d", i),
            64'((i < gorder.size()) ? gorder[i] : -1),
            64'(i % 2));

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      tick();
      for (int r = 0; r < N; r++) begin
        if (saw_done[r]) begin
          req[r] = 1'b0;
        end else if (!req[r]) begin
          if ($urandom_range(2) == 0) begin
            req[r] = 1'b1;
            req_we[r] = 1'($urandom_range(1));
            req_addr[r*AW +: AW] = {$urandom, $urandom};
            req_wdata[r*DW +: DW] = rnd_line();
          end
        end else if (grant[r] && $urandom_range(39) == 0) begin
          req[r] = 1'b0;
        end
      end
      dma_empty   = ($urandom_range(3) != 0);
      dma_full    = ($urandom_range(3) != 0);
      dma_rd_done = ($urandom_range(2) == 0);
      dma_wr_done = ($urandom_range(2) == 0);
      dma_rd_data = rnd_line();
    end

    req = '0;
    dma_empty = 1'b0;
    dma_full = 1'b0;
    dma_rd_done = 1'b1;
    dma_wr_done = 1'b1;
    repeat (40) tick();
    check("final_idle", 64'(busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/host_dma_arbiter.md
HOST_DMA_ARBITER -- requirements
Module: host_dma_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, 2, number of requesters (0 = instruction side, 1 = data side).
- ADDR_WIDTH, 64, virtual byte address width.
- DATA_WIDTH, 512, cache-line width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester level request; held until that requester's done.
- req_we  in  NUM_REQ  1 = write one line, 0 = read one line.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-requester address.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed per-requester write line.
- grant  out  NUM_REQ  one-hot owner of the DMA, held from latch through done.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  out  DATA_WIDTH  last line read; stable from done until next read's done.
- busy  out  1  high whenever FSM is not IDLE.
- dma_rd_go, dma_wr_go  out  1  one-cycle channel start pulses.
- dma_rd_addr, dma_wr_addr  out  ADDR_WIDTH  latched transaction address.
- dma_rd_en  out  1  pop one line from the read channel.
- dma_rd_data  in  DATA_WIDTH  read channel data.
- dma_empty  in  1  read channel has no data.
- dma_rd_done  in  1  read channel finished its size.
- dma_wr_en  out  1  push one line.
- dma_wr_data  out  DATA_WIDTH  latched write line.
- dma_full  in  1  write channel cannot accept.
- dma_wr_done  in  1  write channel finished its size.

Function
REQ-003 Every transfer SHALL be exactly one cache line; the parent ties DMA size to 1.
REQ-004 FSM states SHALL be IDLE, RD_ISSUE, RD_POP, RD_DRAIN, WR_ISSUE, WR_PUSH, WR_DRAIN, DONE.
REQ-005 IDLE: if any req bit is set, the FSM SHALL perform these steps in the same cycle:
- Select the winner round-robin, starting at last_winner+1 modulo NUM_REQ.
- Latch the winner index, addr, we and wdata.
- Set grant one-hot on the next edge.
- Go to WR_ISSUE if we, else RD_ISSUE.
REQ-006 RD_ISSUE SHALL assert dma_rd_go for exactly one cycle, then go to RD_POP.
REQ-007 RD_POP SHALL assert dma_rd_en for one cycle in the first cycle with dma_empty=0, capture dma_rd_data into rdata on that edge, then go to RD_DRAIN.
REQ-008 RD_DRAIN SHALL wait for dma_rd_done=1, then go to DONE.
REQ-009 WR_ISSUE SHALL assert dma_wr_go for exactly one cycle, then go to WR_PUSH.
REQ-010 WR_PUSH SHALL assert dma_wr_en with dma_wr_data = latched wdata in the first cycle with dma_full=0, then go to WR_DRAIN.
REQ-011 WR_DRAIN SHALL wait for dma_wr_done=1, then go to DONE.
REQ-012 DONE SHALL pulse done[winner] for one cycle, update last_winner, clear grant, and return to IDLE.
REQ-013 The arbiter SHALL be idle-eligible the cycle after DONE; requesters drop req on the edge where they see done.
REQ-014 dma_rd_addr and dma_wr_addr SHALL both equal the latched address while grant is set.
REQ-015 Simultaneous requests SHALL be served alternately; no requester waits more than one other transaction.
REQ-016 A req deassertion mid-transaction SHALL NOT abort it; done is still pulsed.
REQ-017 dma_empty=0 or dma_full=0 outside RD_POP or WR_PUSH SHALL be ignored.
REQ-018 At most one of dma_rd_go, dma_wr_go, dma_rd_en and dma_wr_en SHALL be high in any cycle.
REQ-019 Minimum latency SHALL be req-to-rd_go 2 cycles (IDLE latch, RD_ISSUE) and req-to-done 5 cycles with immediate data and done.

Reset
REQ-020 On rst_n=0, asynchronously:
- FSM SHALL go to IDLE.
- grant, done, busy, all dma_* outputs, rdata and latched fields SHALL go to 0.
- last_winner SHALL go to NUM_REQ-1, so requester 0 wins first.
REQ-021 Reset mid-transaction SHALL drop all strobes immediately; no done is issued for the aborted transfer.

Structure
REQ-022 Package host_dma_pkg SHALL hold the FSM state enum and the ADDR_WIDTH and DATA_WIDTH defaults.
REQ-023 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req, last_winner; outputs: one-hot pick, index, any). It SHALL be combinational, with last_winner held in host_dma_arbiter.

Verification
REQ-024 Read with dma_empty low 3 cycles after rd_go and rd_done 1 cycle later: req[1] read at 0x1000, rd_data=0xA5.. -> rd_go one pulse with addr 0x1000, single rd_en, rdata=0xA5.., done[1] one pulse.
REQ-025 Write with dma_full high 4 cycles: req[0] write 0x2040 -> wr_en asserted only after full drops, wr_data matches, done[0] after wr_done.
REQ-026 Contention: req=2'b11 held continuously -> grant order 0,1,0,1, never two grants at once.
REQ-027 Reset mid-op: rst_n low during RD_POP -> all outputs 0 the same cycle; after release, req[0] wins first.
REQ-028 Requester drops req during WR_DRAIN -> transaction completes and done still pulses.
REQ-029 Assertion: the REQ-018 mutual exclusion and grant one-hot-or-zero hold over 10k random cycles.
